// File: rtl/me_ref_mem.sv
// me_ref_mem
//   Memory-side responder for the motion-estimation core's pixel fetches.
//   A raster pixel stream loads either one current macroblock (MACRO_DIM^2
//   pixels) or one search window (SEARCH_DIM^2 pixels) into banked storage.
//   Once both images are loaded, the core reads column vectors combinationally:
//   MACRO_DIM current pixels and MACRO_DIM+1 search pixels rotated by amt.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   load_start, load_sel  start loading current (0) or search (1) image
//   pix_valid, pix_data   raster pixel stream, accepted when pix_ready
//   pix_ready             high while a load is in progress
//   load_done             one-cycle pulse after the last pixel of an image
//   mem_valid             both images loaded
//   en_ram, addr, amt     read request: base address and bank rotation
//   pixel_cpr_in          current-pixel column vector (MACRO_DIM lanes)
//   pixel_spr_in          search-pixel vector (MACRO_DIM+1 lanes)
//   rd_err                registered flag: previous enabled read was zeroed
module me_ref_mem #(
   parameter int unsigned MACRO_DIM  = 16,
   parameter int unsigned SEARCH_DIM = 48,
   parameter int unsigned ADDR_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_start,
   input  logic                          load_sel,
   input  logic                          pix_valid,
   input  logic [7:0]                    pix_data,
   output logic                          pix_ready,
   output logic                          load_done,
   output logic                          mem_valid,
   input  logic                          en_ram,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [5:0]                    amt,
   output logic [MACRO_DIM-1:0][7:0]     pixel_cpr_in,
   output logic [MACRO_DIM:0][7:0]       pixel_spr_in,
   output logic                          rd_err
);

   localparam int unsigned PW    = MACRO_DIM + 1;
   localparam int unsigned NCOL  = (SEARCH_DIM + PW - 1) / PW;
   localparam int unsigned DEPTH = SEARCH_DIM * NCOL;
   localparam int unsigned CB_W  = $clog2(MACRO_DIM);
   localparam int unsigned SB_W  = $clog2(PW);
   localparam int unsigned MAXD  = (SEARCH_DIM > MACRO_DIM) ? SEARCH_DIM : MACRO_DIM;
   localparam int unsigned CNT_W = $clog2(MAXD + 1);

   typedef enum logic [1:0] {IDLE, LOAD_CUR, LOAD_SRCH} state_t;

   state_t               state;
   logic                 cur_loaded;
   logic                 srch_loaded;
   logic [CNT_W-1:0]     row;
   logic [CNT_W-1:0]     col;
   logic [SB_W-1:0]      sb_sel;    // col % PW, tracked incrementally
   logic [ADDR_W-1:0]    sb_base;   // (col / PW) * SEARCH_DIM, tracked incrementally
   logic                 accept;
   logic                 err_c;

   logic [7:0] cbank [MACRO_DIM][MACRO_DIM];
   logic [7:0] sbank [PW][DEPTH];

   assign accept = pix_valid & pix_ready;

   // ------------------------------------------------------------------
   // Load FSM and registered status
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pix_ready   <= 1'b0;
         load_done   <= 1'b0;
         mem_valid   <= 1'b0;
         rd_err      <= 1'b0;
         cur_loaded  <= 1'b0;
         srch_loaded <= 1'b0;
         row         <= '0;
         col         <= '0;
         sb_sel      <= '0;
         sb_base     <= '0;
      end else begin
         load_done <= 1'b0;
         mem_valid <= cur_loaded & srch_loaded;
         rd_err    <= err_c;
         case (state)
            IDLE: begin
               if (load_start) begin
                  pix_ready <= 1'b1;
                  row       <= '0;
                  col       <= '0;
                  sb_sel    <= '0;
                  sb_base   <= '0;
                  if (load_sel) begin
                     state       <= LOAD_SRCH;
                     srch_loaded <= 1'b0;
                  end else begin
                     state      <= LOAD_CUR;
                     cur_loaded <= 1'b0;
                  end
               end
            end
            LOAD_CUR: begin
               if (accept) begin
                  if (col == CNT_W'(MACRO_DIM - 1)) begin
                     col <= '0;
                     if (row == CNT_W'(MACRO_DIM - 1)) begin
                        state      <= IDLE;
                        pix_ready  <= 1'b0;
                        load_done  <= 1'b1;
                        cur_loaded <= 1'b1;
                     end else begin
                        row <= row + CNT_W'(1);
                     end
                  end else begin
                     col <= col + CNT_W'(1);
                  end
               end
            end
            LOAD_SRCH: begin
               if (accept) begin
                  if (col == CNT_W'(SEARCH_DIM - 1)) begin
                     col     <= '0;
                     sb_sel  <= '0;
                     sb_base <= '0;
                     if (row == CNT_W'(SEARCH_DIM - 1)) begin
                        state       <= IDLE;
                        pix_ready   <= 1'b0;
                        load_done   <= 1'b1;
                        srch_loaded <= 1'b1;
                     end else begin
                        row <= row + CNT_W'(1);
                     end
                  end else begin
                     col <= col + CNT_W'(1);
                     if (sb_sel == SB_W'(PW - 1)) begin
                        sb_sel  <= '0;
                        sb_base <= sb_base + ADDR_W'(SEARCH_DIM);
                     end else begin
                        sb_sel <= sb_sel + SB_W'(1);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Pixel storage writes (contents are not reset)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (accept && state == LOAD_CUR)
         cbank[col[CB_W-1:0]][row[CB_W-1:0]] <= pix_data;
      if (accept && state == LOAD_SRCH)
         sbank[sb_sel][sb_base + ADDR_W'(row)] <= pix_data;
   end

   // ------------------------------------------------------------------
   // Zero-latency read path
   // ------------------------------------------------------------------
   logic [6:0]        bsum;
   logic [ADDR_W:0]   lane_a;

   always_comb begin
      pixel_cpr_in = '0;
      pixel_spr_in = '0;
      err_c        = 1'b0;
      bsum         = '0;
      lane_a       = '0;
      if (en_ram) begin
         if (!mem_valid || amt >= 6'(PW)) begin
            err_c = 1'b1;
         end else begin
            if (addr < ADDR_W'(MACRO_DIM)) begin
               for (int unsigned l = 0; l < MACRO_DIM; l++)
                  pixel_cpr_in[l] = cbank[l][addr[CB_W-1:0]];
            end else begin
               err_c = 1'b1;
            end
            // Lanes whose bank wrapped past the rotation point read the
            // next bank column, one SEARCH_DIM block further down.
            for (int unsigned l = 0; l < PW; l++) begin
               bsum = 7'(l) + {1'b0, amt};
               if (bsum >= 7'(PW))
                  bsum = bsum - 7'(PW);
               lane_a = {1'b0, addr} +
                        ((bsum < {1'b0, amt}) ? (ADDR_W+1)'(SEARCH_DIM) : '0);
               if (lane_a < (ADDR_W+1)'(DEPTH))
                  pixel_spr_in[l] = sbank[bsum[SB_W-1:0]][lane_a[ADDR_W-1:0]];
               else
                  err_c = 1'b1;
            end
         end
      end
   end

endmodule
